// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word fetches over a req/ack
// handshake and hands one instruction plus its PC to decode through a
// single-entry slot. Redirects (exc > redirect) flush the slot and retarget
// the PC. A redirect that lands while a request is outstanding is parked in
// a pending register until that ack arrives.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        exc,
    output logic [31:0] pc_plus4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        id_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_q;
    logic        req_q;
    logic        valid_q;
    logic [31:0] inst_q;
    logic [31:0] ifpc_q;

    logic        flush_d;
    logic [31:0] tgt_d;

    // Redirect request and its word-aligned target; exc wins over redirect.
    always_comb begin
        flush_d = exc | redirect;
        tgt_d   = {redirect_target[31:2], 2'b00};
        if (exc) begin
            tgt_d = EXC_VECTOR;
        end
    end

    assign pc_plus4  = pc_q + 32'd4;
    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign if_valid  = valid_q;
    assign if_inst   = inst_q;
    assign if_pc     = ifpc_q;

    // Fetch FSM; the request line and slot are updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= 32'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            inst_q  <= 32'd0;
            ifpc_q  <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        if (flush_d) begin
                            // Data belongs to the old path: drop it, refetch at target.
                            pc_q <= tgt_d;
                        end else begin
                            valid_q <= 1'b1;
                            inst_q  <= imem_rdata;
                            ifpc_q  <= pc_q;
                            pc_q    <= pc_plus4;
                            req_q   <= 1'b0;
                            state_q <= S_HOLD;
                        end
                    end else if (flush_d) begin
                        // Address must stay put until the memory acks, so park the target.
                        pend_q  <= tgt_d;
                        state_q <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        pc_q    <= flush_d ? tgt_d : pend_q;
                        state_q <= S_FETCH;
                    end else if (flush_d) begin
                        pend_q <= tgt_d;
                    end
                end
                S_HOLD: begin
                    if (flush_d) begin
                        valid_q <= 1'b0;
                        pc_q    <= tgt_d;
                        req_q   <= 1'b1;
                        state_q <= S_FETCH;
                    end else if (id_ready) begin
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit. Accepted fetches are pushed to a
// scoreboard when the bench acks them; a negedge monitor pops and compares
// whenever decode takes the slot.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        exc;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } sb_t;

    sb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    pc_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .exc             (exc),
        .pc_plus4        (pc_plus4),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_inst         (if_inst),
        .if_pc           (if_pc),
        .id_ready        (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, release, and step through IDLE so the caller lands in FETCH at RESET_PC.
    task automatic do_reset();
        rst      = 1'b1;
        imem_ack = 1'b0;
        redirect = 1'b0;
        exc      = 1'b0;
        sb_q.delete();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Decode accepts the slot at the coming edge: compare against the scoreboard.
    always @(negedge clk) begin
        if (!rst && if_valid && id_ready && !redirect && !exc) begin
            sb_t e;
            chk("sb_size", 32'(sb_q.size()), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_pc", if_pc, e.pc);
                chk("sb_inst", if_inst, e.inst);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d", total);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        rst             = 1'b1;
        redirect        = 1'b0;
        redirect_target = 32'd0;
        exc             = 1'b0;
        imem_ack        = 1'b0;
        imem_rdata      = 32'd0;
        id_ready        = 1'b1;
        #12;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_ifpc", if_pc, 32'h0);
        chk("rst_pc4", pc_plus4, 32'h4);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("idle_req", 32'(imem_req), 32'd0);
        tick();
        chk("first_req", 32'(imem_req), 32'd1);

        // Straight-line fetch, same-cycle ack, decode always ready.
        for (int k = 0; k < 4; k++) begin
            a = 32'(k) * 32'd4;
            chk("t1_addr", imem_addr, a);
            chk("t1_pc4", pc_plus4, a + 32'd4);
            chk("t1_req", 32'(imem_req), 32'd1);
            chk("t1_vlo", 32'(if_valid), 32'd0);
            imem_ack   = 1'b1;
            imem_rdata = a ^ 32'hA5A5_A5A5;
            sb_q.push_back('{pc: a, inst: a ^ 32'hA5A5_A5A5});
            tick();
            imem_ack = 1'b0;
            chk("t1_vhi", 32'(if_valid), 32'd1);
            chk("t1_hold_req", 32'(imem_req), 32'd0);
            tick();
        end

        // Decode stall: slot must hold still with no new request.
        do_reset();
        id_ready   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hA5A5_A5A5;
        sb_q.push_back('{pc: 32'h0, inst: 32'hA5A5_A5A5});
        tick();
        imem_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t2_valid", 32'(if_valid), 32'd1);
            chk("t2_ifpc", if_pc, 32'h0);
            chk("t2_inst", if_inst, 32'hA5A5_A5A5);
            chk("t2_req", 32'(imem_req), 32'd0);
            tick();
        end
        id_ready = 1'b1;
        tick();
        chk("t2_req_after", 32'(imem_req), 32'd1);
        chk("t2_addr_after", imem_addr, 32'h4);

        // Redirect while a request is outstanding; ack arrives 3 cycles late.
        do_reset();
        redirect        = 1'b1;
        redirect_target = 32'h0000_0403;
        tick();
        redirect = 1'b0;
        chk("t3_addr_w1", imem_addr, 32'h0);
        chk("t3_req_w1", 32'(imem_req), 32'd1);
        tick();
        chk("t3_addr_w2", imem_addr, 32'h0);
        tick();
        chk("t3_addr_w3", imem_addr, 32'h0);
        chk("t3_req_w3", 32'(imem_req), 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_1111;
        tick();
        imem_ack = 1'b0;
        chk("t3_valid", 32'(if_valid), 32'd0);
        chk("t3_req", 32'(imem_req), 32'd1);
        chk("t3_addr", imem_addr, 32'h0000_0400);

        // exc and redirect together in HOLD: exc wins, slot flushed.
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        sb_q.push_back('{pc: 32'h400, inst: 32'hDEAD_BEEF});
        tick();
        imem_ack = 1'b0;
        chk("t4_vhi", 32'(if_valid), 32'd1);
        chk("t4_ifpc", if_pc, 32'h400);
        exc             = 1'b1;
        redirect        = 1'b1;
        redirect_target = 32'h0000_0800;
        tick();
        exc      = 1'b0;
        redirect = 1'b0;
        chk("t4_flush", 32'(if_valid), 32'd0);
        chk("t4_addr", imem_addr, 32'h0000_0180);
        chk("t4_sb", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) void'(sb_q.pop_front());

        // Redirect on the ack cycle: data discarded, refetch at target.
        imem_ack        = 1'b1;
        imem_rdata      = 32'h2222_2222;
        redirect        = 1'b1;
        redirect_target = 32'h0000_1000;
        tick();
        imem_ack = 1'b0;
        redirect = 1'b0;
        chk("t4b_valid", 32'(if_valid), 32'd0);
        chk("t4b_req", 32'(imem_req), 32'd1);
        chk("t4b_addr", imem_addr, 32'h0000_1000);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        sb_q.push_back('{pc: 32'h1000, inst: 32'h1234_5678});
        tick();
        imem_ack = 1'b0;
        chk("t4b_vhi", 32'(if_valid), 32'd1);
        tick();
        chk("t4b_next", imem_addr, 32'h0000_1004);

        // Reset with a full slot, then ignored ack/redirect in IDLE.
        id_ready   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h3333_3333;
        sb_q.push_back('{pc: 32'h1004, inst: 32'h3333_3333});
        tick();
        imem_ack = 1'b0;
        chk("t5_vhi", 32'(if_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(if_valid), 32'd0);
        chk("t5_rst_addr", imem_addr, 32'h0);
        sb_q.delete();
        id_ready = 1'b1;
        @(posedge clk);
        #1;
        rst             = 1'b0;
        imem_ack        = 1'b1;
        imem_rdata      = 32'h4444_4444;
        redirect        = 1'b1;
        redirect_target = 32'h0000_0500;
        tick();
        imem_ack = 1'b0;
        redirect = 1'b0;
        chk("t5_idle_valid", 32'(if_valid), 32'd0);
        chk("t5_idle_addr", imem_addr, 32'h0);
        chk("t5_req_up", 32'(imem_req), 32'd1);
        // Reset while a request is outstanding.
        rst = 1'b1;
        #2;
        chk("t5_req_drop", 32'(imem_req), 32'd0);
        chk("t5_vlo", 32'(if_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Wrap-around: redirect to the top word (low bits forced to 00).
        imem_ack        = 1'b1;
        imem_rdata      = 32'h5555_5555;
        redirect        = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        tick();
        imem_ack = 1'b0;
        redirect = 1'b0;
        chk("t6_addr", imem_addr, 32'hFFFF_FFFC);
        chk("t6_pc4", pc_plus4, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        sb_q.push_back('{pc: 32'hFFFF_FFFC, inst: 32'hCAFE_F00D});
        tick();
        imem_ack = 1'b0;
        chk("t6_vhi", 32'(if_valid), 32'd1);
        chk("t6_ifpc", if_pc, 32'hFFFF_FFFC);
        tick();
        chk("t6_wrap", imem_addr, 32'h0);
        chk("t6_req", 32'(imem_req), 32'd1);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage of the multi-cycle MIPS datapath: holds the program counter, issues word fetches to instruction memory over a req/ack handshake, and presents one fetched instruction with its PC to decode through a single-entry output slot. It sits directly downstream of the 32-bit 2:1 next-PC multiplexer. That mux's output arrives here as `redirect_target` and is registered into the PC. `pc_plus4` is exported back as the mux's sequential-path input.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `EXC_VECTOR`, 32'h0000_0180, PC loaded on exception redirect.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `redirect`  in  1  one-cycle pulse: load `redirect_target` into PC and flush.
- `redirect_target`  in  32  next PC selected by the next-PC mux.
- `exc`  in  1  one-cycle pulse: load `EXC_VECTOR` and flush; overrides `redirect`.
- `pc_plus4`  out  32  current PC + 4, combinational.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, equal to the current PC register.
- `imem_ack`  in  1  one-cycle pulse: `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `if_valid`  out  1  output slot holds an instruction.
- `if_inst`  out  32  instruction in the slot.
- `if_pc`  out  32  PC of `if_inst`.
- `id_ready`  in  1  decode accepts the slot this cycle when `if_valid`=1.

## Operation
- State machine states: IDLE, FETCH, HOLD, DROP.
- `imem_req` = 1 in FETCH and DROP, otherwise 0. Once asserted, `imem_addr` stays stable until the ack cycle.
- Redirect priority: `exc` > `redirect` > sequential. The target's low 2 bits are forced to 00. `pc + 4` wraps 32'hFFFF_FFFC → 32'h0000_0000.
- IDLE: entered only from reset. Goes to FETCH on the next edge.
- FETCH, output slot empty by construction:
  - ack with no redirect: load slot with `if_inst`=`imem_rdata`, `if_pc`=PC, `if_valid`=1; PC ← PC+4; go to HOLD.
  - ack with redirect/exc in the same cycle: discard the data; PC ← target; stay in FETCH.
  - redirect/exc without ack: PC target is latched into a pending register; go to DROP. The address stays at the old PC.
  - otherwise stay in FETCH.
- DROP: wait for ack and discard the data. On the ack edge, PC ← pending target (or a newer redirect arriving that cycle); go to FETCH. A redirect without ack overwrites the pending target and stays in DROP.
- HOLD:
  - `id_ready`=1 with no redirect: `if_valid` ← 0; go to FETCH.
  - redirect/exc: `if_valid` ← 0, regardless of `id_ready`; PC ← target; go to FETCH.
  - otherwise hold all slot contents.
- `if_valid` is never set while a flush is in effect. `if_inst`/`if_pc` retain their last values when `if_valid`=0.

## Timing
- Reset values (asynchronous):
  - state = IDLE, PC = `RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`
  - `if_valid`=0, `if_inst`=0, `if_pc`=0, pending target = 0
- Reset during FETCH/DROP drops `imem_req` immediately. The memory abandons the request; any late ack is ignored because the block is in IDLE.
- Earliest first request: cycle 1 after reset release, with IDLE taking one cycle.
- Latency: ack edge → `if_valid`=1 on the same edge, so it is visible the next cycle.
- Throughput: with a same-cycle ack and `id_ready` held at 1, one instruction per 2 cycles (FETCH, HOLD alternating).
- Redirect to first request at the target:
  - from HOLD or FETCH-with-ack: next cycle.
  - from FETCH-without-ack: one cycle after the outstanding ack.
- `redirect`/`exc` are sampled every cycle in every state except IDLE, where they are ignored.

## Test plan
- Reset, then straight fetch:
  - stimulus: memory acks every request on the request's first cycle, returning `imem_rdata` = address ^ 32'hA5A5_A5A5; `id_ready`=1.
  - required: `if_pc` sequence 0, 4, 8, 12; `if_valid` high every second cycle; `pc_plus4` = PC+4 throughout.
- Decode stall:
  - stimulus: `id_ready`=0 for 5 cycles after the first slot fill.
  - required: `if_valid`, `if_inst`, `if_pc`=0 stay constant; `imem_req`=0; fetch of 4 begins the cycle after `id_ready` rises.
- Redirect during outstanding request:
  - stimulus: ack delayed 3 cycles; `redirect`=1 with `redirect_target`=32'h0000_0403 in the first wait cycle.
  - required: `imem_addr` stays 0 until ack; that data is discarded (`if_valid` stays 0); next request is at 32'h0000_0400.
- Simultaneous events:
  - `exc`=1 and `redirect`=1 in the same HOLD cycle → slot flushed and next request at 32'h0000_0180.
  - redirect on the ack cycle → data discarded and next request at the target.
- Reset mid-fetch and wrap-around:
  - reset asserted while `imem_req`=1 → `imem_req` falls immediately and `if_valid`=0.
  - PC redirected to 32'hFFFF_FFFC, then fetched → next `imem_addr` = 32'h0000_0000.
